// File: rtl/pipelined_crossbar.sv
// Pipelined crossbar: every output owns a small FIFO. Each output picks one
// input through sel_i/req_i. A flit moves into the crossbar only when all of
// the outputs that claim its input have room, so one flit copied to several
// outputs is delivered to all of them or to none of them.
module pipelined_crossbar #(
  parameter  int INPUT_NUM  = 5,
  parameter  int OUTPUT_NUM = 5,
  parameter  int FLIT_WIDTH = 64,
  parameter  int DEPTH      = 2,
  localparam int SEL_SIZE   = $clog2(INPUT_NUM)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [INPUT_NUM-1:0][FLIT_WIDTH-1:0]   data_i,
  input  logic [INPUT_NUM-1:0]                   valid_i,
  output logic [INPUT_NUM-1:0]                   ready_o,
  input  logic [OUTPUT_NUM-1:0][SEL_SIZE-1:0]    sel_i,
  input  logic [OUTPUT_NUM-1:0]                  req_i,
  output logic [OUTPUT_NUM-1:0][FLIT_WIDTH-1:0]  data_o,
  output logic [OUTPUT_NUM-1:0]                  valid_o,
  input  logic [OUTPUT_NUM-1:0]                  ready_i,
  output logic                                   err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      wr_ptr_q [OUTPUT_NUM];
  logic [PTR_W-1:0]      wr_ptr_d [OUTPUT_NUM];
  logic [PTR_W-1:0]      rd_ptr_q [OUTPUT_NUM];
  logic [PTR_W-1:0]      rd_ptr_d [OUTPUT_NUM];
  logic [CNT_W-1:0]      count_q  [OUTPUT_NUM];
  logic [CNT_W-1:0]      count_d  [OUTPUT_NUM];
  logic                  err_q, err_d;
  logic [FLIT_WIDTH-1:0] mem_q    [OUTPUT_NUM][DEPTH];

  logic [OUTPUT_NUM-1:0][INPUT_NUM-1:0] claim;
  logic [OUTPUT_NUM-1:0] full, bad_sel, enq, deq;
  logic [INPUT_NUM-1:0]  has_claim, blocked, xfer;
  logic [FLIT_WIDTH-1:0] enq_data [OUTPUT_NUM];

  // Decode which inputs each output claims, and flag selects that point past the last input.
  always_comb begin
    // NOTE: give every combinational output a value before any branch, so no latch is inferred.
    claim   = '0;
    full    = '0;
    bad_sel = '0;
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      full[j]    = (count_q[j] == CNT_W'(DEPTH));
      bad_sel[j] = req_i[j] && (int'(sel_i[j]) >= INPUT_NUM);
      for (int i = 0; i < INPUT_NUM; i++) begin
        claim[j][i] = req_i[j] && (sel_i[j] == SEL_SIZE'(i));
      end
    end
  end

  // An input is ready when it has at least one claimant and no claimant buffer is full.
  always_comb begin
    has_claim = '0;
    blocked   = '0;
    ready_o   = '0;
    xfer      = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      for (int j = 0; j < OUTPUT_NUM; j++) begin
        has_claim[i] = has_claim[i] | claim[j][i];
        blocked[i]   = blocked[i] | (claim[j][i] & full[j]);
      end
      ready_o[i] = has_claim[i] & ~blocked[i];
      xfer[i]    = valid_i[i] & ready_o[i];
    end
  end

  // Steer each accepted flit to every output that claims it (multicast), then step pointers and counts.
  always_comb begin
    err_d = err_q | (|bad_sel);
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      enq[j]      = 1'b0;
      enq_data[j] = '0;
      for (int i = 0; i < INPUT_NUM; i++) begin
        if (claim[j][i]) begin
          enq[j]      = xfer[i];
          enq_data[j] = data_i[i];
        end
      end
      deq[j]      = valid_o[j] & ready_i[j];
      wr_ptr_d[j] = wr_ptr_q[j] + PTR_W'(enq[j]);
      rd_ptr_d[j] = rd_ptr_q[j] + PTR_W'(deq[j]);
      count_d[j]  = count_q[j] + CNT_W'(enq[j]) - CNT_W'(deq[j]);
    end
  end

  // Output view: the head flit while the buffer is non-empty, otherwise zero.
  always_comb begin
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      valid_o[j] = (count_q[j] != '0);
      data_o[j]  = valid_o[j] ? mem_q[j][rd_ptr_q[j]] : '0;
    end
  end

  assign err_o = err_q;

  // Control state: pointers, occupancy and the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples values from before the edge.
    if (!rst) begin
      err_q <= 1'b0;
      for (int j = 0; j < OUTPUT_NUM; j++) begin
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
        count_q[j]  <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int j = 0; j < OUTPUT_NUM; j++) begin
        wr_ptr_q[j] <= wr_ptr_d[j];
        rd_ptr_q[j] <= rd_ptr_d[j];
        count_q[j]  <= count_d[j];
      end
    end
  end

  // Flit storage: written on enqueue only.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; a zero count hides any stale entries, and data_o is forced to zero when a buffer is empty.
    for (int j = 0; j < OUTPUT_NUM; j++) begin
      if (enq[j]) mem_q[j][wr_ptr_q[j]] <= enq_data[j];
    end
  end

endmodule
